bcd_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 10-way one-hot select resource among 10 requesters.

---
 rtl/bcd_arb_pkg.sv | 24 ++
 rtl/bcd_rr_arbiter_pick.sv | 33 +++
 rtl/bcd_rr_arbiter.sv | 109 ++++++++++
 tb/tb_bcd_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
// Shared types, constants and the BCD-to-one-hot decode for the BCD round-robin arbiter.
package bcd_arb_pkg;

    localparam int unsigned NUM_REQ = 10;
    localparam int unsigned CODE_W  = 4;
    localparam logic [NUM_REQ-1:0] ONEHOT_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    // MSB-first decode: code k drives bit (9-k); codes above 9 decode to nothing.
    function automatic logic [NUM_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [NUM_REQ-1:0] oh;
        oh = ONEHOT_NONE;
        if (code <= CODE_W'(NUM_REQ - 1)) begin
            oh = {1'b1, {(NUM_REQ-1){1'b0}}} >> code;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bcd_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after last+1, wrapping 9->0.
module rr_pick10
    import bcd_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [CODE_W-1:0]  last,
    output logic               found,
    output logic [CODE_W-1:0]  idx
);

    logic [CODE_W:0] base;
    logic [CODE_W:0] cand;

    // Scan the ten positions in rotation order and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // An out-of-range pointer is treated as 9 so requester 0 is scanned first.
        base  = (last > CODE_W'(NUM_REQ - 1)) ? (CODE_W+1)'(NUM_REQ - 1) : {1'b0, last};
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = base + (CODE_W+1)'(1) + (CODE_W+1)'(k);
            if (cand >= (CODE_W+1)'(NUM_REQ)) begin
                cand = cand - (CODE_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[CODE_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[CODE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bcd_rr_arbiter.sv
// Round-robin arbiter for ten requesters sharing one one-hot select resource.
// Grants are held until release or MAX_HOLD cycles, followed by a one-cycle gap.
module bcd_rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_REQ-1:0]  req,
    output logic                grant_valid,
    output logic [CODE_W-1:0]   grant_code,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic                timeout
);

    arb_state_t          state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CODE_W-1:0]   last_q, last_d;
    logic                valid_q, valid_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [NUM_REQ-1:0]  onehot_q, onehot_d;
    logic                timeout_q, timeout_d;

    logic                pick_found;
    logic [CODE_W-1:0]   pick_idx;

    rr_pick10 u_pick (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic; all outputs are registered copies of these.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_d    = last_q;
        valid_d   = valid_q;
        code_d    = code_q;
        onehot_d  = onehot_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && pick_found) begin
                    state_d  = GRANT;
                    hold_d   = HOLD_W'(1);
                    last_d   = pick_idx;
                    valid_d  = 1'b1;
                    code_d   = pick_idx;
                    onehot_d = code_to_onehot(pick_idx);
                end
            end
            GRANT: begin
                // Voluntary release wins over timeout when both happen in the same cycle.
                if (!req[code_q] || (hold_q == HOLD_W'(MAX_HOLD))) begin
                    state_d   = GAP;
                    hold_d    = '0;
                    valid_d   = 1'b0;
                    code_d    = '0;
                    onehot_d  = ONEHOT_NONE;
                    timeout_d = req[code_q];
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                hold_d   = '0;
                valid_d  = 1'b0;
                code_d   = '0;
                onehot_d = ONEHOT_NONE;
            end
        endcase
    end

    // State, counter, pointer and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            last_q    <= CODE_W'(NUM_REQ - 1);
            valid_q   <= 1'b0;
            code_q    <= '0;
            onehot_q  <= ONEHOT_NONE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            onehot_q  <= onehot_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid  = valid_q;
    assign grant_code   = code_q;
    assign grant_onehot = onehot_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_bcd_rr_arbiter.sv
// Directed bench for bcd_rr_arbiter: a per-cycle vector table plus multi-cycle sequences.
module tb_bcd_rr_arbiter;

    typedef struct packed {
        logic       en;
        logic [9:0] req;
        logic       gv;
        logic [3:0] code;
        logic [9:0] oh;
        logic       to;
    } vec_t;

    localparam int unsigned NVEC = 18;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] req;
    logic       grant_valid;
    logic [3:0] grant_code;
    logic [9:0] grant_onehot;
    logic       timeout;

    int unsigned n_checks;
    int unsigned n_fail;

    vec_t vecs [NVEC];

    bcd_rr_arbiter #(
        .MAX_HOLD (15),
        .HOLD_W   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_code   (grant_code),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] exp_oh(input int unsigned k);
        logic [9:0] v;
        v = '0;
        v[9 - k] = 1'b1;
        return v;
    endfunction

    initial begin
        int unsigned n;
        n_checks = 0;
        n_fail   = 0;

        // en, req, grant_valid, grant_code, grant_onehot, timeout (after the edge)
        vecs[0]  = '{1'b1, 10'h001, 1'b1, 4'd0, 10'h200, 1'b0};
        vecs[1]  = '{1'b1, 10'h001, 1'b1, 4'd0, 10'h200, 1'b0};
        vecs[2]  = '{1'b1, 10'h000, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[3]  = '{1'b1, 10'h008, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[4]  = '{1'b1, 10'h008, 1'b1, 4'd3, 10'h040, 1'b0};
        vecs[5]  = '{1'b1, 10'h0AA, 1'b1, 4'd3, 10'h040, 1'b0};
        vecs[6]  = '{1'b1, 10'h0AA, 1'b1, 4'd3, 10'h040, 1'b0};
        vecs[7]  = '{1'b1, 10'h0AA, 1'b1, 4'd3, 10'h040, 1'b0};
        vecs[8]  = '{1'b1, 10'h082, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[9]  = '{1'b1, 10'h082, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[10] = '{1'b1, 10'h082, 1'b1, 4'd7, 10'h004, 1'b0};
        vecs[11] = '{1'b0, 10'h082, 1'b1, 4'd7, 10'h004, 1'b0};
        vecs[12] = '{1'b0, 10'h002, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[13] = '{1'b0, 10'h3FF, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[14] = '{1'b0, 10'h3FF, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[15] = '{1'b0, 10'h3FF, 1'b0, 4'd0, 10'h000, 1'b0};
        vecs[16] = '{1'b1, 10'h3FF, 1'b1, 4'd8, 10'h002, 1'b0};
        vecs[17] = '{1'b1, 10'h100, 1'b1, 4'd8, 10'h002, 1'b0};

        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        #12;
        check("reset_valid",   32'(grant_valid),  32'd0);
        check("reset_code",    32'(grant_code),   32'd0);
        check("reset_onehot",  32'(grant_onehot), 32'd0);
        check("reset_timeout", 32'(timeout),      32'd0);
        do_reset();

        // Per-cycle vector table
        for (int i = 0; i < int'(NVEC); i++) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            step();
            check($sformatf("vec%0d_valid", i),   32'(grant_valid),  32'(vecs[i].gv));
            check($sformatf("vec%0d_code", i),    32'(grant_code),   32'(vecs[i].code));
            check($sformatf("vec%0d_onehot", i),  32'(grant_onehot), 32'(vecs[i].oh));
            check($sformatf("vec%0d_timeout", i), 32'(timeout),      32'(vecs[i].to));
        end

        // All requesters active: rotation 0..9,0, each ended by timeout after 15 cycles
        do_reset();
        en  = 1'b1;
        req = 10'h3FF;
        step();
        for (int unsigned g = 0; g <= 10; g++) begin
            check($sformatf("rr%0d_valid", g),  32'(grant_valid),  32'd1);
            check($sformatf("rr%0d_code", g),   32'(grant_code),   32'(g % 10));
            check($sformatf("rr%0d_onehot", g), 32'(grant_onehot), 32'(exp_oh(g % 10)));
            n = 1;
            step();
            while (grant_valid && n < 40) begin
                n++;
                step();
            end
            check($sformatf("rr%0d_hold_len", g),    n,                  32'd15);
            check($sformatf("rr%0d_gap_timeout", g), 32'(timeout),       32'd1);
            check($sformatf("rr%0d_gap_onehot", g),  32'(grant_onehot),  32'd0);
            step();
            check($sformatf("rr%0d_idle_valid", g),   32'(grant_valid), 32'd0);
            check($sformatf("rr%0d_idle_timeout", g), 32'(timeout),     32'd0);
            step();
        end

        // Holder releases in the exact cycle hold reaches the limit: no timeout pulse
        do_reset();
        en  = 1'b1;
        req = 10'h001;
        step();
        repeat (14) step();
        check("lim_still_valid", 32'(grant_valid), 32'd1);
        req = 10'h000;
        step();
        check("lim_release_valid",   32'(grant_valid), 32'd0);
        check("lim_release_timeout", 32'(timeout),     32'd0);

        // Lone holder times out and is re-granted after gap and idle
        do_reset();
        en  = 1'b1;
        req = 10'h020;
        step();
        check("solo_code", 32'(grant_code), 32'd5);
        repeat (15) step();
        check("solo_timeout", 32'(timeout), 32'd1);
        step();
        check("solo_idle_valid", 32'(grant_valid), 32'd0);
        step();
        check("solo_regrant_valid", 32'(grant_valid), 32'd1);
        check("solo_regrant_code",  32'(grant_code),  32'd5);

        // Asynchronous reset mid-grant, then pointer is back at 9
        do_reset();
        en  = 1'b1;
        req = 10'h080;
        step();
        step();
        check("ar_code7", 32'(grant_code), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",  32'(grant_valid),  32'd0);
        check("ar_code",   32'(grant_code),   32'd0);
        check("ar_onehot", 32'(grant_onehot), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 10'h081;
        step();
        check("ar_regrant_valid", 32'(grant_valid), 32'd1);
        check("ar_regrant_code",  32'(grant_code),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
